dsp_result_collector: RTL and testbench



---
 rtl/dsp_result_collector_pkg.sv | 16 +
 rtl/dsp_result_collector_if.sv | 29 ++
 rtl/dsp_result_fifo.sv | 63 ++++++
 rtl/dsp_result_collector.sv | 93 +++++++++
 tb/tb_dsp_result_collector.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_result_collector_pkg.sv
// Shared constants and helpers for the DSP result collector and its FIFO.
// Provides the default P width, credit-counter sizing and pointer wrap.
package dsp_result_collector_pkg;

    localparam int PWIDTH = 48;

    // Credits count 0..DEPTH inclusive, so one extra code point is needed.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_advance(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dsp_result_collector_if.sv
// Issue/result handshake bundle between the DSP issue side, the collector and
// the downstream consumer; the slave modport is the collector's view.
interface dsp_result_collector_if
    import dsp_result_collector_pkg::*;
#(
    parameter int WIDTH = PWIDTH,
    parameter int DEPTH = 8
);
    localparam int CW = credit_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    credits;

    modport master (
        output in_valid, p_in, out_ready,
        input  in_ready, out_valid, out_data, credits
    );

    modport slave (
        input  in_valid, p_in, out_ready,
        output in_ready, out_valid, out_data, credits
    );

endinterface

// File: rtl/dsp_result_fifo.sv
// Result FIFO with first-word fall-through read; DEPTH need not be a power of
// two, so both pointers wrap explicitly at DEPTH-1.
module dsp_result_fifo
    import dsp_result_collector_pkg::*;
#(
    parameter int WIDTH = PWIDTH,
    parameter int DEPTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_full;

    assign w_full  = (r_count == CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_rd    = i_rd_en & o_valid;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= PW'(ptr_advance(int'(r_wr_ptr), DEPTH));
            end
            if (w_rd) begin
                r_rd_ptr <= PW'(ptr_advance(int'(r_rd_ptr), DEPTH));
            end
            if (i_wr_en && !w_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!i_wr_en && w_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage carries no reset; o_data is masked while empty.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Credit gating upstream must make a capture into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_wr_en && w_full));

endmodule

// File: rtl/dsp_result_collector.sv
// Issues operands into a fixed-latency DSP pipe and collects its P results.
// Define DSP_RESULT_COLLECTOR_STATS_EN to add saturating pop/stall counters.
module dsp_result_collector
    import dsp_result_collector_pkg::*;
#(
    parameter int WIDTH   = PWIDTH,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    dsp_result_collector_if.slave bus
`ifdef DSP_RESULT_COLLECTOR_STATS_EN
    ,
    output logic [31:0]           stat_results,
    output logic [31:0]           stat_stall
`endif
);
    localparam int CW = credit_width(DEPTH);

    logic [LATENCY-1:0] r_tokens;
    logic [CW-1:0]      r_credits;
    logic               w_in_ready;
    logic               w_issue;
    logic               w_pop;
    logic               w_capture;
    logic               w_out_valid;

    // Credits cover in-flight plus stored results, so every landing token has room.
    assign w_in_ready = (r_credits < CW'(DEPTH));
    assign w_issue    = bus.in_valid & w_in_ready;
    assign w_pop      = w_out_valid & bus.out_ready;
    assign w_capture  = r_tokens[LATENCY-1];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.credits   = r_credits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tokens <= '0;
        end else begin
            r_tokens <= (r_tokens << 1) | LATENCY'(w_issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= '0;
        end else if (w_issue && !w_pop) begin
            r_credits <= r_credits + CW'(1);
        end else if (!w_issue && w_pop && (r_credits != '0)) begin
            r_credits <= r_credits - CW'(1);
        end
    end

    dsp_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_capture),
        .i_wr_data (bus.p_in),
        .i_rd_en   (bus.out_ready),
        .o_valid   (w_out_valid),
        .o_data    (bus.out_data)
    );

`ifdef DSP_RESULT_COLLECTOR_STATS_EN
    logic [31:0] r_stat_results;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_results <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_pop && (r_stat_results != '1)) begin
                r_stat_results <= r_stat_results + 32'd1;
            end
            if (bus.in_valid && !w_in_ready && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_results = r_stat_results;
    assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Drives two collector configurations (L=4/D=8 and L=3/D=5) with shared
// valid/ready stimulus and checks both against an issue-history reference model.
module tb_dsp_result_collector;
    import dsp_result_collector_pkg::*;

    localparam int LAT_A = 4;
    localparam int DEP_A = 8;
    localparam int LAT_B = 3;
    localparam int DEP_B = 5;
    localparam int NMAX  = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp_result_collector_if #(.WIDTH(48), .DEPTH(DEP_A)) ifa ();
    dsp_result_collector_if #(.WIDTH(48), .DEPTH(DEP_B)) ifb ();

`ifdef DSP_RESULT_COLLECTOR_STATS_EN
    logic [31:0] stat_res_a, stat_stall_a, stat_res_b, stat_stall_b;
`endif

    dsp_result_collector #(.WIDTH(48), .LATENCY(LAT_A), .DEPTH(DEP_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
`ifdef DSP_RESULT_COLLECTOR_STATS_EN
        ,
        .stat_results (stat_res_a),
        .stat_stall   (stat_stall_a)
`endif
    );

    dsp_result_collector #(.WIDTH(48), .LATENCY(LAT_B), .DEPTH(DEP_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
`ifdef DSP_RESULT_COLLECTOR_STATS_EN
        ,
        .stat_results (stat_res_b),
        .stat_stall   (stat_stall_b)
`endif
    );

    // Reference model: ordered issue history per DUT. Result k is captured at
    // edge (issue edge + latency); credits = issued - popped.
    logic [47:0] m_data [2][NMAX];
    int          m_edge [2][NMAX];
    int          n_iss [2];
    int          n_cap [2];
    int          n_pop [2];
    int          m_pops_total [2];
    int          m_stall [2];
    int          edge_cnt;
    int          checks;
    int          errors;
    logic        in_valid_v;
    logic        out_ready_v;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? DEP_A : DEP_B;
    endfunction

    function automatic logic [47:0] rnd48();
        logic [63:0] g;
        g = {$urandom, $urandom};
        return g[47:0];
    endfunction

    function automatic logic [63:0] obs(input int d, input int which);
        logic [63:0] v;
        v = 64'd0;
        case (which)
            0: v = (d == 0) ? {63'd0, ifa.in_ready}  : {63'd0, ifb.in_ready};
            1: v = (d == 0) ? {63'd0, ifa.out_valid} : {63'd0, ifb.out_valid};
            2: v = (d == 0) ? {16'd0, ifa.out_data}  : {16'd0, ifb.out_data};
            default: v = (d == 0) ? 64'(ifa.credits) : 64'(ifb.credits);
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic r);
        in_valid_v    = v;
        out_ready_v   = r;
        ifa.in_valid  = v;
        ifb.in_valid  = v;
        ifa.out_ready = r;
        ifb.out_ready = r;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            n_iss[d] = 0;
            n_cap[d] = 0;
            n_pop[d] = 0;
            m_pops_total[d] = 0;
            m_stall[d] = 0;
        end
    endtask

    task automatic check_model(input int d);
        int   cr;
        logic ov;
        cr = n_iss[d] - n_pop[d];
        ov = (n_pop[d] < n_cap[d]);
        chk("in_ready", d, obs(d, 0), (cr < dep_of(d)) ? 64'd1 : 64'd0);
        chk("out_valid", d, obs(d, 1), {63'd0, ov});
        chk("out_data", d, obs(d, 2), ov ? {16'd0, m_data[d][n_pop[d]]} : 64'd0);
        chk("credits", d, obs(d, 3), 64'(cr));
`ifdef DSP_RESULT_COLLECTOR_STATS_EN
        chk("stat_results", d, (d == 0) ? 64'(stat_res_a) : 64'(stat_res_b), 64'(m_pops_total[d]));
        chk("stat_stall", d, (d == 0) ? 64'(stat_stall_a) : 64'(stat_stall_b), 64'(m_stall[d]));
`endif
    endtask

    // One clock cycle: drive p_in, check at negedge, advance model on posedge.
    task automatic step(input logic [47:0] da, input logic [47:0] db);
        logic [47:0] nd [2];
        logic [47:0] pv;
        bit          cap [2];
        bit          iss [2];
        bit          pop [2];
        bit          stall [2];
        nd[0] = da;
        nd[1] = db;
        for (int d = 0; d < 2; d++) begin
            cap[d] = (n_cap[d] < n_iss[d]) && (m_edge[d][n_cap[d]] + lat_of(d) == edge_cnt + 1);
            pv = cap[d] ? m_data[d][n_cap[d]] : rnd48();
            if (d == 0) ifa.p_in = pv;
            else        ifb.p_in = pv;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_model(d);
            iss[d]   = in_valid_v && ((n_iss[d] - n_pop[d]) < dep_of(d));
            stall[d] = in_valid_v && !iss[d];
            pop[d]   = out_ready_v && (n_pop[d] < n_cap[d]);
        end
        @(posedge clk);
        edge_cnt++;
        for (int d = 0; d < 2; d++) begin
            if (iss[d] && n_iss[d] < NMAX) begin
                m_data[d][n_iss[d]] = nd[d];
                m_edge[d][n_iss[d]] = edge_cnt;
                n_iss[d]++;
            end
            if (cap[d]) n_cap[d]++;
            if (pop[d]) begin
                n_pop[d]++;
                m_pops_total[d]++;
            end
            if (stall[d]) m_stall[d]++;
        end
        #1;
    endtask

    // Called 1 time unit after a posedge; reset lands mid-cycle.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", d, obs(d, 0), 64'd1);
            chk("rst_out_valid", d, obs(d, 1), 64'd0);
            chk("rst_out_data", d, obs(d, 2), 64'd0);
            chk("rst_credits", d, obs(d, 3), 64'd0);
        end
        clear_model();
        repeat (2) begin
            ifa.p_in = rnd48();
            ifb.p_in = rnd48();
            @(posedge clk);
        end
        @(negedge clk);
        set_in(1'b0, out_ready_v);
        rst_n = 1'b1;
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        clear_model();
        ifa.p_in = '0;
        ifb.p_in = '0;
        set_in(1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Reset with in_valid high, then idle: nothing may be captured.
        do_reset();
        set_in(1'b0, 1'b1);
        repeat (LAT_A + 2) step(rnd48(), rnd48());

        // Single issue latency check.
        while (edge_cnt < 9) step(rnd48(), rnd48());
        set_in(1'b1, 1'b0);
        step(48'h0000_1234_5678, 48'h0000_1234_5678);
        set_in(1'b0, 1'b0);
        repeat (LAT_A) step(rnd48(), rnd48());
        chk("lat_valid", 0, {63'd0, ifa.out_valid}, 64'd1);
        chk("lat_data", 0, {16'd0, ifa.out_data}, 64'h0000_0000_1234_5678);
        set_in(1'b0, 1'b1);
        step(rnd48(), rnd48());
        chk("lat_credits", 0, 64'(ifa.credits), 64'd0);
        step(rnd48(), rnd48());

        // Back-to-back throughput.
        set_in(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(48'(i), 48'(i));
        set_in(1'b0, 1'b1);
        repeat (8) step(rnd48(), rnd48());

        // Consumer stall: credits must saturate at DEPTH.
        set_in(1'b1, 1'b0);
        repeat (12) step(rnd48(), rnd48());
        chk("bp_credits", 0, 64'(ifa.credits), 64'(DEP_A));
        chk("bp_in_ready", 0, {63'd0, ifa.in_ready}, 64'd0);
        chk("bp_credits", 1, 64'(ifb.credits), 64'(DEP_B));
        set_in(1'b0, 1'b1);
        repeat (12) step(rnd48(), rnd48());

        // Toggling out_ready forces pointer wrap and capture-with-pop cycles.
        for (int i = 0; i < 80; i++) begin
            set_in(1'b1, (i % 2) == 0);
            step(rnd48(), rnd48());
        end
        set_in(1'b0, 1'b1);
        repeat (10) step(rnd48(), rnd48());

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            step(rnd48(), rnd48());
        end
        set_in(1'b0, 1'b1);
        repeat (12) step(rnd48(), rnd48());

        // Mid-operation reset: 2 stored, 3 in flight on dut0.
        set_in(1'b1, 1'b0);
        repeat (5) step(rnd48(), rnd48());
        set_in(1'b0, 1'b0);
        step(rnd48(), rnd48());
        chk("pre_rst_credits", 0, 64'(ifa.credits), 64'd5);
        chk("pre_rst_valid", 0, {63'd0, ifa.out_valid}, 64'd1);
        do_reset();
        set_in(1'b0, 1'b1);
        repeat (LAT_A + 4) step(rnd48(), rnd48());

        // Recovery after reset.
        set_in(1'b1, 1'b1);
        repeat (10) step(rnd48(), rnd48());
        set_in(1'b0, 1'b1);
        repeat (8) step(rnd48(), rnd48());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
